// File: rtl/psum_row_drain_if.sv
// rtl/psum_row_drain_if.sv - output beat stream interface for psum_row_drain
//
// Purpose: carries one requantized activation per beat from the drain to the
//          sparse activation consumer.
// Signals:
//   PSDOUT_Vld   beat valid           (master -> slave)
//   PSDOUT_Rdy   consumer ready       (slave  -> master)
//   PSDOUT_Act   activation value     (master -> slave)
//   PSDOUT_Flg   activation nonzero   (master -> slave)
//   PSDOUT_Last  last element of row  (master -> slave)
interface psum_row_drain_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  PSDOUT_Vld;
  logic                  PSDOUT_Rdy;
  logic [DATA_WIDTH-1:0] PSDOUT_Act;
  logic                  PSDOUT_Flg;
  logic                  PSDOUT_Last;

  modport master (
    output PSDOUT_Vld,
    input  PSDOUT_Rdy,
    output PSDOUT_Act,
    output PSDOUT_Flg,
    output PSDOUT_Last
  );

  modport slave (
    input  PSDOUT_Vld,
    output PSDOUT_Rdy,
    input  PSDOUT_Act,
    input  PSDOUT_Flg,
    input  PSDOUT_Last
  );
endinterface

// File: rtl/psum_row_drain.sv
// rtl/psum_row_drain.sv - captures a psum row, requantizes and streams it out
//
// Purpose: on CNVPSD_Ld, latches LENPSUM partial sums plus shift/ReLU config,
//          then emits one requantized activation per beat (round, arithmetic
//          shift, saturate, optional ReLU) with a nonzero flag.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   CNVPSD_Ld       load pulse, row psums are final
//   CNVPSD_Psum     packed row, element i at [PSUM_WIDTH*i +: PSUM_WIDTH]
//   CFG_Shift       right-shift amount, sampled at load
//   CFG_Relu        ReLU enable, sampled at load
//   PSDCNV_Rdy      idle, a load will be accepted
//   PSDCNV_Fnh      one-cycle pulse after the last beat transfers
//   out_if          output beat stream (master side)
module psum_row_drain #(
  parameter int DATA_WIDTH  = 8,
  parameter int BLOCK_DEPTH = 32,
  parameter int PSUM_WIDTH  = DATA_WIDTH*2 + $clog2(BLOCK_DEPTH) + 2,
  parameter int LENPSUM     = 16,
  parameter int SHIFT_WIDTH = $clog2(PSUM_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          CNVPSD_Ld,
  input  logic [PSUM_WIDTH*LENPSUM-1:0] CNVPSD_Psum,
  input  logic [SHIFT_WIDTH-1:0]        CFG_Shift,
  input  logic                          CFG_Relu,
  output logic                          PSDCNV_Rdy,
  output logic                          PSDCNV_Fnh,
  psum_row_drain_if.master              out_if
);

  localparam int IDX_W = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENPSUM - 1);
  localparam logic signed [PSUM_WIDTH:0] ACT_MAX =
    (PSUM_WIDTH+1)'((1 << (DATA_WIDTH - 1)) - 1);
  // Bitwise complement of 2^(W-1)-1 is exactly -2^(W-1).
  localparam logic signed [PSUM_WIDTH:0] ACT_MIN = ~ACT_MAX;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [PSUM_WIDTH*LENPSUM-1:0] psum_q;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic                          relu_q;
  logic                          fnh_q, fnh_d;
  logic                          load_en;
  logic                          vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      psum_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      fnh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fnh_q   <= fnh_d;
      if (load_en) begin
        psum_q  <= CNVPSD_Psum;
        shift_q <= CFG_Shift;
        relu_q  <= CFG_Relu;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_en    = 1'b0;
    fnh_d      = 1'b0;
    vld        = 1'b0;
    PSDCNV_Rdy = 1'b0;
    unique case (state_q)
      IDLE: begin
        PSDCNV_Rdy = 1'b1;
        if (CNVPSD_Ld) begin
          load_en = 1'b1;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        vld = 1'b1;
        if (out_if.PSDOUT_Rdy) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
            fnh_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requantization is purely combinational from captured state, so the beat
  // is valid the cycle after load and cannot change while stalled.
  logic signed [PSUM_WIDTH-1:0] elem;
  logic [SHIFT_WIDTH-1:0]       s_eff;
  logic signed [PSUM_WIDTH:0]   rnd;
  logic signed [PSUM_WIDTH:0]   t;
  logic signed [PSUM_WIDTH:0]   q;
  logic [DATA_WIDTH-1:0]        act;

  always_comb begin
    elem  = psum_q[PSUM_WIDTH*idx_q +: PSUM_WIDTH];
    s_eff = (shift_q >= SHIFT_WIDTH'(PSUM_WIDTH)) ? SHIFT_WIDTH'(PSUM_WIDTH - 1) : shift_q;
    rnd   = '0;
    if (s_eff != '0) rnd[s_eff - 1'b1] = 1'b1;
    // One extra bit of headroom keeps the rounding add from wrapping.
    t = $signed({elem[PSUM_WIDTH-1], elem}) + rnd;
    q = t >>> s_eff;
    if (q > ACT_MAX)      act = ACT_MAX[DATA_WIDTH-1:0];
    else if (q < ACT_MIN) act = ACT_MIN[DATA_WIDTH-1:0];
    else                  act = q[DATA_WIDTH-1:0];
    if (relu_q && act[DATA_WIDTH-1]) act = '0;
  end

  assign out_if.PSDOUT_Vld  = vld;
  assign out_if.PSDOUT_Act  = vld ? act : '0;
  assign out_if.PSDOUT_Flg  = vld & (act != '0);
  assign out_if.PSDOUT_Last = vld & (idx_q == LAST_IDX);
  assign PSDCNV_Fnh         = fnh_q;

endmodule

// File: tb/tb_psum_row_drain.sv
// tb/tb_psum_row_drain.sv - self-checking bench for psum_row_drain
module tb_psum_row_drain;
  localparam int DW  = 8;
  localparam int PW  = 23;
  localparam int LEN = 16;
  localparam int SW  = 5;

  typedef int row_t[LEN];
  typedef struct {
    int psum;
    int shift;
    bit relu;
    int want;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld = 1'b0;
  logic [PW*LEN-1:0] psum_bus = '0;
  logic [SW-1:0]     shift = '0;
  logic              relu = 1'b0;
  logic              rdy;
  logic              fnh;

  psum_row_drain_if #(.DATA_WIDTH(DW)) out_if ();

  psum_row_drain #(
    .DATA_WIDTH(DW), .BLOCK_DEPTH(32), .PSUM_WIDTH(PW), .LENPSUM(LEN), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CNVPSD_Ld(ld), .CNVPSD_Psum(psum_bus),
    .CFG_Shift(shift), .CFG_Relu(relu), .PSDCNV_Rdy(rdy), .PSDCNV_Fnh(fnh),
    .out_if(out_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference: real-valued rounding then flooring shift, clamp, ReLU.
  function automatic int model(input int p, input int s, input bit r);
    longint t, q;
    int se;
    se = (s >= PW) ? PW - 1 : s;
    t  = p;
    if (se > 0) t = t + (longint'(1) << (se - 1));
    q = t >>> se;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    if (r && q < 0) q = 0;
    return int'(q);
  endfunction

  function automatic int rand_psum();
    int v;
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 600)) - 300;
    v = int'($urandom);
    return v >>> (32 - PW);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_row(input row_t row, input int s, input bit r);
    for (int i = 0; i < LEN; i++) psum_bus[PW*i +: PW] = row[i][PW-1:0];
    shift = s[SW-1:0];
    relu  = r;
    ld    = 1'b1;
    step();
    ld = 1'b0;
    chk("vld_after_load", out_if.PSDOUT_Vld, 1);
    chk("rdy_after_load", rdy, 0);
  endtask

  task automatic drain(input row_t exp, input bit rand_rdy, input int n_beats,
                       input int busy_ld_beat);
    int beat = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    longint h_act = 0;
    bit h_flg = 1'b0;
    bit h_last = 1'b0;
    while (beat < n_beats && cyc < 1000) begin
      cyc++;
      chk("vld_during_drain", out_if.PSDOUT_Vld, 1);
      if (stalled) begin
        chk("stall_act", $signed(out_if.PSDOUT_Act), h_act);
        chk("stall_flg", out_if.PSDOUT_Flg, h_flg);
        chk("stall_last", out_if.PSDOUT_Last, h_last);
      end
      out_if.PSDOUT_Rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (beat == busy_ld_beat) begin
        ld       = 1'b1;
        psum_bus = ~psum_bus;
        shift    = shift + 5'd3;
        relu     = ~relu;
      end
      if (out_if.PSDOUT_Rdy) begin
        chk("beat_act", $signed(out_if.PSDOUT_Act), exp[beat]);
        chk("beat_flg", out_if.PSDOUT_Flg, (exp[beat] != 0) ? 1 : 0);
        chk("beat_last", out_if.PSDOUT_Last, (beat == LEN - 1) ? 1 : 0);
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_act   = $signed(out_if.PSDOUT_Act);
        h_flg   = out_if.PSDOUT_Flg;
        h_last  = out_if.PSDOUT_Last;
      end
      step();
      ld = 1'b0;
    end
    out_if.PSDOUT_Rdy = 1'b1;
    if (beat < n_beats) chk("drain_timeout_beats", beat, n_beats);
  endtask

  task automatic check_fnh();
    chk("fnh_pulse", fnh, 1);
    chk("rdy_on_fnh", rdy, 1);
    chk("vld_on_fnh", out_if.PSDOUT_Vld, 0);
  endtask

  task automatic check_fnh_drop();
    step();
    chk("fnh_one_cycle", fnh, 0);
    chk("idle_rdy", rdy, 1);
  endtask

  vec_t tbl[11];
  row_t row, exp;

  initial begin
    tbl[0]  = '{24, 4, 1'b0, 2};
    tbl[1]  = '{23, 4, 1'b0, 1};
    tbl[2]  = '{-24, 4, 1'b0, -1};
    tbl[3]  = '{-25, 4, 1'b0, -2};
    tbl[4]  = '{300, 0, 1'b0, 127};
    tbl[5]  = '{-300, 0, 1'b0, -128};
    tbl[6]  = '{300, 0, 1'b1, 127};
    tbl[7]  = '{-300, 0, 1'b1, 0};
    tbl[8]  = '{-4194304, 31, 1'b0, -1};
    tbl[9]  = '{4194303, 22, 1'b0, 1};
    tbl[10] = '{5, 1, 1'b0, 3};

    out_if.PSDOUT_Rdy = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    step();
    chk("reset_vld", out_if.PSDOUT_Vld, 0);
    chk("reset_rdy", rdy, 1);
    chk("reset_fnh", fnh, 0);
    chk("reset_act", out_if.PSDOUT_Act, 0);
    chk("reset_flg", out_if.PSDOUT_Flg, 0);
    chk("reset_last", out_if.PSDOUT_Last, 0);
    rst_n = 1'b1;
    step();
    chk("idle_vld", out_if.PSDOUT_Vld, 0);

    // Identity row: -8..7 with zero at element 8.
    for (int i = 0; i < LEN; i++) begin
      row[i] = i - 8;
      exp[i] = i - 8;
    end
    load_row(row, 0, 1'b0);
    drain(exp, 1'b0, LEN, -1);
    check_fnh();
    check_fnh_drop();

    // Table vectors: every element of the row carries the same psum.
    for (int v = 0; v < 11; v++) begin
      for (int i = 0; i < LEN; i++) begin
        row[i] = tbl[v].psum;
        exp[i] = tbl[v].want;
      end
      load_row(row, tbl[v].shift, tbl[v].relu);
      drain(exp, 1'b0, LEN, -1);
      check_fnh();
      check_fnh_drop();
    end

    // Random rows under random backpressure.
    for (int r = 0; r < 8; r++) begin
      int s;
      bit rl;
      s  = int'($urandom_range(0, 31));
      rl = 1'($urandom_range(0, 1));
      for (int i = 0; i < LEN; i++) begin
        row[i] = rand_psum();
        exp[i] = model(row[i], s, rl);
      end
      load_row(row, s, rl);
      drain(exp, 1'b1, LEN, -1);
      check_fnh();
      check_fnh_drop();
    end

    // Load while busy is ignored; a load on the Fnh cycle is accepted.
    for (int i = 0; i < LEN; i++) begin
      row[i] = rand_psum();
      exp[i] = model(row[i], 6, 1'b0);
    end
    load_row(row, 6, 1'b0);
    drain(exp, 1'b1, LEN, 3);
    check_fnh();
    for (int i = 0; i < LEN; i++) begin
      row[i] = rand_psum();
      exp[i] = model(row[i], 2, 1'b1);
    end
    load_row(row, 2, 1'b1);
    drain(exp, 1'b0, LEN, -1);
    check_fnh();
    check_fnh_drop();

    // Reset mid-drain abandons the row without Fnh.
    for (int i = 0; i < LEN; i++) begin
      row[i] = 100 + i;
      exp[i] = model(row[i], 1, 1'b0);
    end
    load_row(row, 1, 1'b0);
    drain(exp, 1'b0, 5, -1);
    rst_n = 1'b0;
    step();
    chk("midrst_vld", out_if.PSDOUT_Vld, 0);
    chk("midrst_rdy", rdy, 1);
    chk("midrst_fnh", fnh, 0);
    chk("midrst_act", out_if.PSDOUT_Act, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_fnh_after", fnh, 0);
    chk("midrst_vld_after", out_if.PSDOUT_Vld, 0);
    for (int i = 0; i < LEN; i++) begin
      row[i] = -50 * i;
      exp[i] = model(row[i], 3, 1'b0);
    end
    load_row(row, 3, 1'b0);
    drain(exp, 1'b0, LEN, -1);
    check_fnh();
    check_fnh_drop();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
